// File: rtl/irq_arbiter_if.sv
// Interrupt arbiter bus: raw lines and CSR control in, grant and trap request out.
interface irq_arbiter_if;
  logic       ext_irq_i;
  logic       sw_irq_i;
  logic       timer_irq_i;
  logic       mstatus_mie_i;
  logic [2:0] mie_i;
  logic       wfi_i;
  logic       trap_ack_i;
  logic       mret_i;
  logic [2:0] irq_o;
  logic       irq_req_o;
  logic [3:0] irq_cause_o;
  logic [2:0] pending_o;
  logic       wfi_sleep_o;

  modport master (
    output ext_irq_i, sw_irq_i, timer_irq_i, mstatus_mie_i, mie_i, wfi_i, trap_ack_i, mret_i,
    input  irq_o, irq_req_o, irq_cause_o, pending_o, wfi_sleep_o
  );

  modport slave (
    input  ext_irq_i, sw_irq_i, timer_irq_i, mstatus_mie_i, mie_i, wfi_i, trap_ack_i, mret_i,
    output irq_o, irq_req_o, irq_cause_o, pending_o, wfi_sleep_o
  );
endinterface

// File: rtl/irq_arbiter.sv
// Machine-mode interrupt arbiter: sync, mask, fixed priority ext > sw > timer, trap handshake.
// Optional WFI sleep state enabled by defining NOX_IRQ_ARB_WFI_EN.
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) chain <= '0;
    else      chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];
endmodule

module irq_arbiter #(
  parameter int SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          rst,
  irq_arbiter_if.slave bus
);
  localparam int NUM_LINES = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
`ifdef NOX_IRQ_ARB_WFI_EN
    ,
    SLEEP  = 2'd3
`endif
  } state_t;

  state_t               state, state_n;
  logic [NUM_LINES-1:0] raw, pending, eligible;
  logic [NUM_LINES-1:0] grant, grant_n, sel;
  logic [3:0]           cause, cause_n, sel_cause;
  logic                 req;
  logic                 fireable;

  // Bit order {timer, sw, ext} matches mie_i and the CSR irq struct.
  assign raw = {bus.timer_irq_i, bus.sw_irq_i, bus.ext_irq_i};

  irq_sync #(.STAGES(SYNC_STAGES)) u_sync [NUM_LINES-1:0] (
    .clk (clk),
    .rst (rst),
    .d   (raw),
    .q   (pending)
  );

  assign eligible = pending & bus.mie_i;
  assign fireable = (|eligible) & bus.mstatus_mie_i;

  always_comb begin
    sel       = '0;
    sel_cause = 4'd0;
    if (eligible[0]) begin
      sel       = 3'b001;
      sel_cause = 4'd11;
    end else if (eligible[1]) begin
      sel       = 3'b010;
      sel_cause = 4'd3;
    end else if (eligible[2]) begin
      sel       = 3'b100;
      sel_cause = 4'd7;
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    cause_n = cause;
    case (state)
      IDLE: begin
        if (fireable) begin
          state_n = REQ;
          grant_n = sel;
          cause_n = sel_cause;
        end
`ifdef NOX_IRQ_ARB_WFI_EN
        else if (bus.wfi_i) state_n = SLEEP;
`endif
      end
      REQ: begin
        // Grant is frozen; only an ack or loss of the granted source moves us.
        if (bus.trap_ack_i) begin
          state_n = ACTIVE;
        end else if (!(|(grant & eligible)) || !bus.mstatus_mie_i) begin
          state_n = IDLE;
          grant_n = '0;
          cause_n = 4'd0;
        end
      end
      ACTIVE: begin
        if (bus.mret_i) begin
          state_n = IDLE;
          grant_n = '0;
          cause_n = 4'd0;
        end
      end
`ifdef NOX_IRQ_ARB_WFI_EN
      SLEEP: begin
        // Any enabled pending line wakes the hart, even with global MIE off.
        if (|eligible) begin
          if (bus.mstatus_mie_i) begin
            state_n = REQ;
            grant_n = sel;
            cause_n = sel_cause;
          end else begin
            state_n = IDLE;
          end
        end
      end
`endif
      default: begin
        state_n = IDLE;
        grant_n = '0;
        cause_n = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      grant <= '0;
      cause <= 4'd0;
      req   <= 1'b0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      cause <= cause_n;
      req   <= (state_n == REQ);
    end
  end

  assign bus.irq_o       = grant;
  assign bus.irq_req_o   = req;
  assign bus.irq_cause_o = cause;
  assign bus.pending_o   = pending;

`ifdef NOX_IRQ_ARB_WFI_EN
  assign bus.wfi_sleep_o = (state == SLEEP);
`else
  logic unused_wfi;
  assign unused_wfi      = bus.wfi_i;
  assign bus.wfi_sleep_o = 1'b0;
`endif
endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter; grants are scoreboarded on each irq_req_o rising edge.
module tb_irq_arbiter;
  localparam int SS = 2;

  typedef struct packed {
    logic [2:0] irq;
    logic [3:0] cause;
  } exp_t;

  logic clk;
  logic rst;
  int   passes;
  int   checks;
  exp_t sb[$];

  irq_arbiter_if ifc ();

  irq_arbiter #(.SYNC_STAGES(SS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int budget);
    int n;
    n = 0;
    while (ifc.irq_req_o !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk("wait_req", ifc.irq_req_o, 1);
  endtask

  task automatic pulse_ack();
    ifc.trap_ack_i = 1'b1;
    step();
    ifc.trap_ack_i = 1'b0;
  endtask

  task automatic pulse_mret();
    ifc.mret_i = 1'b1;
    step();
    ifc.mret_i = 1'b0;
  endtask

  // Grant monitor: every new request must match the oldest expected grant.
  initial begin
    logic req_prev;
    exp_t e;
    req_prev = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (ifc.irq_req_o === 1'b1 && !req_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_req", ifc.irq_req_o, 0);
        end else begin
          e = sb.pop_front();
          chk("grant_irq", ifc.irq_o, e.irq);
          chk("grant_cause", ifc.irq_cause_o, e.cause);
        end
      end
      req_prev = ifc.irq_req_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    passes = 0;
    checks = 0;
    rst = 1'b0;
    ifc.ext_irq_i = 0; ifc.sw_irq_i = 0; ifc.timer_irq_i = 0;
    ifc.mstatus_mie_i = 0; ifc.mie_i = 3'b000;
    ifc.wfi_i = 0; ifc.trap_ack_i = 0; ifc.mret_i = 0;

    #12;
    chk("rst_irq", ifc.irq_o, 0);
    chk("rst_req", ifc.irq_req_o, 0);
    chk("rst_cause", ifc.irq_cause_o, 0);
    chk("rst_pending", ifc.pending_o, 0);
    chk("rst_sleep", ifc.wfi_sleep_o, 0);
    step();
    rst = 1'b1;
    step();

    // ext + timer together: ext wins, request after SS+1 cycles
    ifc.mie_i = 3'b111;
    ifc.mstatus_mie_i = 1'b1;
    sb.push_back('{irq: 3'b001, cause: 4'd11});
    ifc.ext_irq_i = 1'b1;
    ifc.timer_irq_i = 1'b1;
    for (int c = 1; c <= SS + 1; c++) begin
      step();
      chk("latency_req", ifc.irq_req_o, (c == SS + 1));
      if (c == SS) chk("pending", ifc.pending_o, 3'b101);
    end
    pulse_ack();
    chk("ack_req_drop", ifc.irq_req_o, 0);
    chk("active_irq", ifc.irq_o, 3'b001);
    ifc.ext_irq_i = 1'b0;
    ifc.timer_irq_i = 1'b0;
    repeat (SS + 2) step();
    chk("active_hold", ifc.irq_o, 3'b001);
    pulse_mret();
    chk("mret_irq", ifc.irq_o, 0);
    chk("mret_cause", ifc.irq_cause_o, 0);
    repeat (2) step();

    // timer granted, later ext must not preempt or nest
    sb.push_back('{irq: 3'b100, cause: 4'd7});
    ifc.timer_irq_i = 1'b1;
    wait_req(SS + 3);
    ifc.ext_irq_i = 1'b1;
    repeat (SS + 1) step();
    chk("no_preempt_irq", ifc.irq_o, 3'b100);
    chk("no_preempt_cause", ifc.irq_cause_o, 7);
    pulse_ack();
    chk("ack_cause", ifc.irq_cause_o, 7);
    chk("ack_req", ifc.irq_req_o, 0);
    repeat (3) step();
    chk("no_nest", ifc.irq_req_o, 0);
    sb.push_back('{irq: 3'b001, cause: 4'd11});
    pulse_mret();
    chk("mret_clear", ifc.irq_o, 0);
    wait_req(3);
    chk("after_mret_cause", ifc.irq_cause_o, 11);
    pulse_ack();
    ifc.ext_irq_i = 1'b0;
    ifc.timer_irq_i = 1'b0;
    repeat (SS + 2) step();
    pulse_mret();
    repeat (2) step();

    // sw granted then dropped before ack: request withdrawn
    sb.push_back('{irq: 3'b010, cause: 4'd3});
    ifc.sw_irq_i = 1'b1;
    wait_req(SS + 3);
    ifc.sw_irq_i = 1'b0;
    n = 0;
    while (ifc.irq_req_o === 1'b1 && n < SS + 1) begin
      step();
      n++;
    end
    chk("withdraw_req", ifc.irq_req_o, 0);
    chk("withdraw_cause", ifc.irq_cause_o, 0);
    chk("withdraw_irq", ifc.irq_o, 0);
    repeat (3) step();
    chk("idle_stays", ifc.irq_req_o, 0);
    ifc.trap_ack_i = 1'b1;
    ifc.mret_i = 1'b1;
    step();
    ifc.trap_ack_i = 1'b0;
    ifc.mret_i = 1'b0;
    repeat (2) step();
    chk("stray_req", ifc.irq_req_o, 0);
    chk("stray_irq", ifc.irq_o, 0);

    // global MIE cleared while requesting: withdrawn
    sb.push_back('{irq: 3'b001, cause: 4'd11});
    ifc.ext_irq_i = 1'b1;
    wait_req(SS + 3);
    ifc.mstatus_mie_i = 1'b0;
    step();
    chk("mie_withdraw_req", ifc.irq_req_o, 0);
    chk("mie_withdraw_cause", ifc.irq_cause_o, 0);
    ifc.ext_irq_i = 1'b0;
    repeat (SS + 2) step();
    ifc.mstatus_mie_i = 1'b1;
    step();

`ifdef NOX_IRQ_ARB_WFI_EN
    // sleep, woken by timer with MIE off: resume without request
    ifc.mie_i = 3'b100;
    ifc.mstatus_mie_i = 1'b0;
    ifc.wfi_i = 1'b1;
    step();
    ifc.wfi_i = 1'b0;
    chk("sleep_enter", ifc.wfi_sleep_o, 1);
    ifc.timer_irq_i = 1'b1;
    n = 0;
    while (ifc.wfi_sleep_o === 1'b1 && n < SS + 3) begin
      step();
      n++;
    end
    chk("sleep_wake", ifc.wfi_sleep_o, 0);
    repeat (2) step();
    chk("wake_no_req", ifc.irq_req_o, 0);
    ifc.timer_irq_i = 1'b0;
    repeat (SS + 2) step();
    // same with MIE on: wake straight into a request
    ifc.mstatus_mie_i = 1'b1;
    ifc.wfi_i = 1'b1;
    step();
    ifc.wfi_i = 1'b0;
    chk("sleep_enter2", ifc.wfi_sleep_o, 1);
    sb.push_back('{irq: 3'b100, cause: 4'd7});
    ifc.timer_irq_i = 1'b1;
    wait_req(SS + 2);
    chk("wake_cause", ifc.irq_cause_o, 7);
    chk("wake_sleep_off", ifc.wfi_sleep_o, 0);
    pulse_ack();
    ifc.timer_irq_i = 1'b0;
    repeat (SS + 2) step();
    pulse_mret();
    repeat (2) step();
`else
    // wfi ignored: no sleep, FSM still idle and ready
    ifc.wfi_i = 1'b1;
    step();
    ifc.wfi_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("no_sleep", ifc.wfi_sleep_o, 0);
      step();
    end
    sb.push_back('{irq: 3'b001, cause: 4'd11});
    ifc.ext_irq_i = 1'b1;
    wait_req(SS + 1);
    pulse_ack();
    ifc.ext_irq_i = 1'b0;
    repeat (SS + 2) step();
    pulse_mret();
    repeat (2) step();
`endif
    ifc.mie_i = 3'b111;
    ifc.mstatus_mie_i = 1'b1;

    // reset while ACTIVE: outputs clear without a clock edge
    sb.push_back('{irq: 3'b001, cause: 4'd11});
    ifc.ext_irq_i = 1'b1;
    wait_req(SS + 3);
    pulse_ack();
    chk("pre_rst_irq", ifc.irq_o, 3'b001);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_irq", ifc.irq_o, 0);
    chk("arst_req", ifc.irq_req_o, 0);
    chk("arst_cause", ifc.irq_cause_o, 0);
    chk("arst_pending", ifc.pending_o, 0);
    ifc.ext_irq_i = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    repeat (SS + 3) step();
    chk("post_rst_req", ifc.irq_req_o, 0);
    chk("post_rst_irq", ifc.irq_o, 0);
    chk("post_rst_cause", ifc.irq_cause_o, 0);
    chk("post_rst_sleep", ifc.wfi_sleep_o, 0);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the number of flops in each raw-interrupt synchronizer (legal 2..4).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous, active-low (0 = reset).
REQ-004 ext_irq_i / sw_irq_i / timer_irq_i  input  1 each  SHALL carry raw, level-sensitive, possibly asynchronous interrupt lines.
REQ-005 mstatus_mie_i  input  1  SHALL carry the current global machine interrupt enable.
REQ-006 mie_i  input  3  SHALL carry the per-source enables {MTIE, MSIE, MEIE} as bits [2:0] = {timer, sw, ext}.
REQ-007 wfi_i  input  1  SHALL carry a one-cycle pulse when a WFI retires in execute.
REQ-008 trap_ack_i  input  1  SHALL carry a one-cycle pulse when the CSR unit commits the requested trap.
REQ-009 mret_i  input  1  SHALL carry a one-cycle pulse when an MRET retires.
REQ-010 irq_o  output  3  SHALL present the granted source one-hot {timer, sw, ext}, in the same bit order the CSR irq struct uses.
REQ-011 irq_req_o  output  1  SHALL request a trap from the CSR unit.
REQ-012 irq_cause_o  output  4  SHALL give the granted mcause code: 11 ext, 3 sw, 7 timer, 0 none.
REQ-013 pending_o  output  3  SHALL give the synchronized, unmasked pending lines (for MIP mirroring).
REQ-014 wfi_sleep_o  output  1  SHALL request a fetch/issue stall while the hart sleeps.

Function
REQ-015 Each raw line SHALL pass through a SYNC_STAGES-deep flop chain; pending_o = chain outputs.
REQ-016 eligible[i] SHALL equal pending[i] & mie_i[i]; fireable SHALL equal |eligible & mstatus_mie_i.
REQ-017 Priority SHALL be fixed: ext > sw > timer.
REQ-018 The FSM SHALL have four states: IDLE, REQ, ACTIVE, SLEEP; its state, irq_o, irq_req_o and irq_cause_o SHALL all be registered.
REQ-019 IDLE: if fireable, go to REQ and latch the highest-priority eligible source into irq_o/irq_cause_o; otherwise, if wfi_i, go to SLEEP; otherwise stay.
REQ-020 IDLE: if fireable and wfi_i occur in the same cycle, the FSM SHALL go to REQ (interrupt wins).
REQ-021 REQ: irq_req_o=1; irq_o/irq_cause_o SHALL stay frozen (no preemption by a later higher-priority source).
REQ-022 REQ: trap_ack_i SHALL move the FSM to ACTIVE; irq_req_o drops the following cycle.
REQ-023 REQ: if, without trap_ack_i, the granted source is no longer eligible or mstatus_mie_i=0, the request SHALL be withdrawn: go to IDLE, clear irq_o and set irq_cause_o=0.
REQ-024 REQ: trap_ack_i SHALL take precedence over a simultaneous withdrawal.
REQ-025 ACTIVE: no new request (no nesting); irq_o SHALL hold the granted source; mret_i SHALL go to IDLE and clear irq_o/irq_cause_o.
REQ-026 SLEEP: wfi_sleep_o=1; on |eligible (regardless of mstatus_mie_i), leave SLEEP next cycle: to REQ if mstatus_mie_i=1 (with grant latched as in REQ-019), else to IDLE (resume after WFI).
REQ-027 Latency: raw edge to irq_req_o=1 SHALL be SYNC_STAGES+1 cycles from IDLE or SLEEP.
REQ-028 Unexpected trap_ack_i outside REQ and mret_i outside ACTIVE SHALL be ignored.

Reset
REQ-029 While rst=0: FSM=IDLE, synchronizers=0, irq_o=0, irq_req_o=0, irq_cause_o=0, pending_o=0, wfi_sleep_o=0, applied immediately and held until the first clock edge after release.
REQ-030 Reset asserted in any state SHALL abort that operation; no request SHALL resume after release unless re-triggered.

Configuration
REQ-031 Macro NOX_IRQ_ARB_WFI_EN defined: the SLEEP state and REQ-026 SHALL be implemented.
REQ-032 Macro NOX_IRQ_ARB_WFI_EN undefined: SLEEP SHALL be absent, wfi_i SHALL be ignored, wfi_sleep_o SHALL be tied 0; all other behaviour SHALL be unchanged.

Verification
REQ-033 mie_i=3'b111, MIE=1, ext and timer raised together -> irq_req_o at cycle 3 (SYNC_STAGES=2), irq_o=3'b001, irq_cause_o=11.
REQ-034 In REQ with timer granted, raise ext, then ack -> grant stays timer (irq_cause_o=7); ext is not requested until after mret_i.
REQ-035 Grant sw, drop sw_irq_i before ack -> irq_req_o=0 and irq_cause_o=0 within SYNC_STAGES+1 cycles; FSM back in IDLE.
REQ-036 WFI_EN defined, wfi_i pulse, MIE=0, mie_i=3'b100, raise timer -> wfi_sleep_o 1 then 0, no irq_req_o; same with MIE=1 -> irq_req_o=1 with irq_cause_o=7.
REQ-037 Reset pulse (rst=0) while in ACTIVE -> all outputs 0 asynchronously; after release with lines low, FSM stays in IDLE.
REQ-038 WFI_EN undefined, wfi_i pulse -> wfi_sleep_o stays 0 and the FSM stays in IDLE.
